// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin arbiter that lets NREQ requesters share one register. Each
//   grant is a single-cycle write pulse. The clear request beats every write.
//   Optional feature macro: REG_ARB_LOCK_EN. When it is defined, the iLock
//   port and the LOCK state are added. A requester granted with its lock bit
//   set then keeps the grant until that lock bit drops.
//
// Ports
//   iClk      clock, rising edge
//   iRstN     asynchronous active-low reset
//   iReq      [NREQ]           per-requester write request
//   iData     [NREQ*BITWIDTH]  write data, requester i at [i*BITWIDTH +: BITWIDTH]
//   iClr      global clear request
//   iLock     [NREQ]           lock request (only with REG_ARB_LOCK_EN)
//   oGnt      [NREQ]           registered one-hot grant
//   oRegEn    registered write enable to the shared register
//   oRegClr   registered clear to the shared register
//   oRegData  [BITWIDTH]       registered write data
//   oLocked   high while in LOCK (tied 0 without REG_ARB_LOCK_EN)
module reg_write_arbiter #(
  parameter int BITWIDTH = 32,
  parameter int NREQ     = 4
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic [NREQ-1:0]          iReq,
  input  logic [NREQ*BITWIDTH-1:0] iData,
  input  logic                     iClr,
`ifdef REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]          iLock,
`endif
  output logic [NREQ-1:0]          oGnt,
  output logic                     oRegEn,
  output logic                     oRegClr,
  output logic [BITWIDTH-1:0]      oRegData,
  output logic                     oLocked
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef REG_ARB_LOCK_EN
  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;
`else
  typedef enum logic {ST_ARB = 1'b0} state_t;
`endif

  state_t                r_state,   w_stateNxt;
  logic [PTR_W-1:0]      r_ptr,     w_ptrNxt;
  logic [NREQ-1:0]       r_gnt,     w_gntNxt;
  logic                  r_en,      w_enNxt;
  logic                  r_clr,     w_clrNxt;
  logic [BITWIDTH-1:0]   r_data,    w_dataNxt;
`ifdef REG_ARB_LOCK_EN
  logic [PTR_W-1:0]      r_lockIdx, w_lockIdxNxt;
`endif

  logic                  w_found;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W-1:0]      w_cand;

  // (w + 1) mod NREQ
  function automatic logic [PTR_W-1:0] f_nextPtr(input logic [PTR_W-1:0] w);
    if (int'(w) == NREQ - 1) return '0;
    return PTR_W'(int'(w) + 1);
  endfunction

  function automatic logic [BITWIDTH-1:0] f_selData(input logic [PTR_W-1:0] w);
    return iData[int'(w)*BITWIDTH +: BITWIDTH];
  endfunction

  // Upward search from r_ptr with wrap; the first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % NREQ);
      if (!w_found && iReq[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_stateNxt   = r_state;
    w_ptrNxt     = r_ptr;
    w_gntNxt     = '0;
    w_enNxt      = 1'b0;
    w_clrNxt     = 1'b0;
    w_dataNxt    = r_data;
`ifdef REG_ARB_LOCK_EN
    w_lockIdxNxt = r_lockIdx;
`endif
    case (r_state)
`ifdef REG_ARB_LOCK_EN
      ST_LOCK: begin
        if (iClr) begin
          w_clrNxt   = 1'b1;
          w_stateNxt = ST_ARB;
        end else begin
          if (iReq[r_lockIdx]) begin
            w_gntNxt[r_lockIdx] = 1'b1;
            w_enNxt             = 1'b1;
            w_dataNxt           = f_selData(r_lockIdx);
          end
          // Dropping the lock returns to round-robin; a final write (if any)
          // still rotates the pointer past the locked requester.
          if (!iLock[r_lockIdx]) begin
            w_stateNxt = ST_ARB;
            if (iReq[r_lockIdx]) w_ptrNxt = f_nextPtr(r_lockIdx);
          end
        end
      end
`endif
      default: begin
        if (iClr) begin
          w_clrNxt = 1'b1;
        end else if (w_found) begin
          w_gntNxt[w_win] = 1'b1;
          w_enNxt         = 1'b1;
          w_dataNxt       = f_selData(w_win);
          w_ptrNxt        = f_nextPtr(w_win);
`ifdef REG_ARB_LOCK_EN
          if (iLock[w_win]) begin
            w_stateNxt   = ST_LOCK;
            w_lockIdxNxt = w_win;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state   <= ST_ARB;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_en      <= 1'b0;
      r_clr     <= 1'b0;
      r_data    <= '0;
`ifdef REG_ARB_LOCK_EN
      r_lockIdx <= '0;
`endif
    end else begin
      r_state   <= w_stateNxt;
      r_ptr     <= w_ptrNxt;
      r_gnt     <= w_gntNxt;
      r_en      <= w_enNxt;
      r_clr     <= w_clrNxt;
      r_data    <= w_dataNxt;
`ifdef REG_ARB_LOCK_EN
      r_lockIdx <= w_lockIdxNxt;
`endif
    end
  end

  assign oGnt     = r_gnt;
  assign oRegEn   = r_en;
  assign oRegClr  = r_clr;
  assign oRegData = r_data;
`ifdef REG_ARB_LOCK_EN
  assign oLocked  = (r_state == ST_LOCK);
`else
  assign oLocked  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0001;
  localparam logic [31:0] D2 = 32'hA5A5_0001;
  localparam logic [31:0] D3 = 32'h4444_0003;

  logic         iClk = 1'b0;
  logic         iRstN;
  logic [3:0]   iReq;
  logic [127:0] iData;
  logic         iClr;
  logic [3:0]   iLock;
  logic [3:0]   oGnt;
  logic         oRegEn;
  logic         oRegClr;
  logic [31:0]  oRegData;
  logic         oLocked;

  int n_checks = 0;
  int n_fail   = 0;

  reg_write_arbiter #(.BITWIDTH(32), .NREQ(4)) dut (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iReq     (iReq),
    .iData    (iData),
    .iClr     (iClr),
`ifdef REG_ARB_LOCK_EN
    .iLock    (iLock),
`endif
    .oGnt     (oGnt),
    .oRegEn   (oRegEn),
    .oRegClr  (oRegClr),
    .oRegData (oRegData),
    .oLocked  (oLocked)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [3:0]  req;
    logic        clr;
    logic [3:0]  gnt;
    logic        en;
    logic        clrO;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] gnt, input logic en,
                         input logic clr, input logic [31:0] data, input logic lck);
    chk({nm, ".gnt"},    32'(oGnt),    32'(gnt));
    chk({nm, ".en"},     32'(oRegEn),  32'(en));
    chk({nm, ".clr"},    32'(oRegClr), 32'(clr));
    chk({nm, ".data"},   oRegData,     data);
    chk({nm, ".locked"}, 32'(oLocked), 32'(lck));
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    iRstN = 1'b0;
    #3;
    @(posedge iClk);
    #1;
    iRstN = 1'b1;
  endtask

  initial begin
    iRstN = 1'b0;
    iReq  = '0;
    iClr  = 1'b0;
    iLock = '0;
    iData = {D3, D2, D1, D0};

    // Vector table: inputs sampled at one edge, outputs expected in the next cycle.
    tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, D2}; // single pulse, ptr->3
    tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, D2}; // idle, data holds
    tbl[2]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, D0}; // wrap from ptr=3, ptr->1
    tbl[3]  = '{4'b0110, 1'b0, 4'b0010, 1'b1, 1'b0, D1}; // ptr=1 picks 1 over 2
    tbl[4]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0, D3}; // ptr->0
    tbl[5]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, D0};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, D1};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, D2};
    tbl[8]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, D3};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, D0};
    tbl[10] = '{4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, D1};
    tbl[11] = '{4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, D2};
    tbl[12] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, D3}; // ptr->0
    tbl[13] = '{4'b1010, 1'b1, 4'b0000, 1'b0, 1'b1, D3}; // clear wins, ptr holds
    tbl[14] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 1'b0, D1}; // from ptr=0 -> 1
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, D1};

    #2;
    chk_all("reset", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge iClk);
    #1;
    iRstN = 1'b1;

    for (int i = 0; i < 16; i++) begin
      iReq = tbl[i].req;
      iClr = tbl[i].clr;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].en, tbl[i].clrO, tbl[i].data, 1'b0);
    end
    iReq = '0;
    iClr = 1'b0;

    // Single pulse followed by an all-quiet cycle right after reset.
    do_reset();
    iReq = 4'b0100;
    step();
    chk_all("pulse", 4'b0100, 1'b1, 1'b0, D2, 1'b0);
    iReq = 4'b0000;
    step();
    chk("pulse_after.gnt", 32'(oGnt), 32'h0);
    chk("pulse_after.en",  32'(oRegEn), 32'h0);
    chk("pulse_after.clr", 32'(oRegClr), 32'h0);

`ifdef REG_ARB_LOCK_EN
    do_reset();
    iReq  = 4'b1111;
    iLock = 4'b0010;
    step();
    chk_all("lk_first", 4'b0001, 1'b1, 1'b0, D0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("lk_hold%0d", i), 4'b0010, 1'b1, 1'b0, D1, 1'b1);
    end
    iLock = 4'b0000;
    step();
    chk_all("lk_final", 4'b0010, 1'b1, 1'b0, D1, 1'b0);
    step();
    chk_all("lk_rr2", 4'b0100, 1'b1, 1'b0, D2, 1'b0);
    step();
    chk_all("lk_rr3", 4'b1000, 1'b1, 1'b0, D3, 1'b0);
    step();
    chk_all("lk_rr0", 4'b0001, 1'b1, 1'b0, D0, 1'b0);
    // ptr is now 1: re-enter LOCK on requester 1.
    iLock = 4'b0010;
    step();
    chk_all("lk_reenter", 4'b0010, 1'b1, 1'b0, D1, 1'b1);
`else
    do_reset();
    iReq = 4'b1111;
    step();
    chk_all("grant_before_rst", 4'b0001, 1'b1, 1'b0, D0, 1'b0);
`endif

    // Asynchronous reset in the middle of the grant/lock cycle.
    #2;
    iRstN = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge iClk);
    #1;
    iRstN = 1'b1;
    iLock = 4'b0000;
    iReq  = 4'b1100;
    step();
    chk_all("post_rst", 4'b0100, 1'b1, 1'b0, D2, 1'b0);
    iReq = 4'b0000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
